// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI widths and BRESP encodings
package axi_pkg;
  localparam int DEF_ID_W = 4;
  localparam int DEF_MID_W = 4;
  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } bresp_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter searching from ptr+1, pointer follows the last winner
module rr_arbiter #(
  parameter int N = 5,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_i,
  input  logic          advance_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic [IW-1:0] ptr_o
);
  logic [IW-1:0] ptr_q, ptr_d;
  logic found;
  always_comb begin
    gnt_o = '0;
    gnt_idx_o = ptr_q;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      if (!found && req_i[(int'(ptr_q) + i) % N]) begin
        found = 1'b1;
        gnt_idx_o = IW'((int'(ptr_q) + i) % N);
        gnt_o[(int'(ptr_q) + i) % N] = 1'b1;
      end
    end
    ptr_d = advance_i && found ? gnt_idx_o : ptr_q;
  end
  always_ff @(posedge clk) ptr_q <= rst ? IW'(N - 1) : ptr_d;
  assign ptr_o = ptr_q;
endmodule

// File: rtl/axi_b_router.sv
// axi_b_router: routes B responses from NUM_S slaves to NUM_M masters by the BID master field
module axi_b_router import axi_pkg::*; #(
  parameter int NUM_S = 5,
  parameter int NUM_M = 2,
  parameter int ID_W  = DEF_ID_W,
  parameter int MID_W = DEF_MID_W
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_S-1:0][ID_W+MID_W-1:0]    bid_s,
  input  logic [NUM_S-1:0][1:0]               bresp_s,
  input  logic [NUM_S-1:0]                    bvalid_s,
  output logic [NUM_S-1:0]                    bready_s,
  output logic [NUM_M-1:0][ID_W-1:0]          bid_m,
  output logic [NUM_M-1:0][1:0]               bresp_m,
  output logic [NUM_M-1:0]                    bvalid_m,
  input  logic [NUM_M-1:0]                    bready_m,
  output logic                                route_err
);
  localparam int SW = NUM_S > 1 ? $clog2(NUM_S) : 1;
  logic [NUM_S-1:0] bad;
  logic [NUM_M-1:0][NUM_S-1:0] req, gnt;
  logic [NUM_M-1:0][SW-1:0] gidx;
  logic [NUM_M-1:0] acc;
  logic route_err_q;
  always_comb begin
    for (int s = 0; s < NUM_S; s++)
      bad[s] = bvalid_s[s] && int'(bid_s[s][ID_W+MID_W-1:ID_W]) >= NUM_M;
    for (int m = 0; m < NUM_M; m++)
      for (int s = 0; s < NUM_S; s++)
        req[m][s] = bvalid_s[s] && int'(bid_s[s][ID_W+MID_W-1:ID_W]) == m;
  end
  // Unroutable responses are consumed on sight so they cannot stall the bus.
  always_comb begin
    bready_s = bad;
    for (int m = 0; m < NUM_M; m++) bready_s = bready_s | (gnt[m] & {NUM_S{acc[m]}});
  end
  for (genvar m = 0; m < NUM_M; m++) begin : g_m
    logic vld_q;
    logic [ID_W-1:0] id_q;
    logic [1:0] resp_q;
    logic xfer;
    assign acc[m] = !vld_q || bready_m[m];
    assign xfer = |req[m] && acc[m];
    rr_arbiter #(.N(NUM_S)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req_i     (req[m]),
      .advance_i (acc[m]),
      .gnt_o     (gnt[m]),
      .gnt_idx_o (gidx[m]),
      .ptr_o     ()
    );
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
        id_q <= '0;
        resp_q <= '0;
      end else if (xfer) begin
        vld_q <= 1'b1;
        id_q <= bid_s[gidx[m]][ID_W-1:0];
        resp_q <= bresp_s[gidx[m]];
      end else if (bready_m[m]) begin
        vld_q <= 1'b0;
      end
    end
    assign bvalid_m[m] = vld_q;
    assign bid_m[m] = id_q;
    assign bresp_m[m] = resp_q;
  end
  always_ff @(posedge clk) route_err_q <= rst ? 1'b0 : route_err_q | (|bad);
  assign route_err = route_err_q;
endmodule
